hex_display_scan: RTL

//   Time-multiplexed driver for NUM_DIGITS hex 7-segment digits that share one segment bus.

---
 rtl/hex_display_scan.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hex_display_scan.sv
// hex_display_scan: time-multiplexed driver for NUM_DIGITS hex 7-segment digits.
// The digits share one active-low segment bus (seg[0]=a .. seg[6]=g) and each
// digit has its own active-low anode. New values are double-buffered: a load
// lands in a pending buffer and is promoted to the display register only at
// the frame boundary, so a frame never shows a mix of old and new nibbles.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module hex_display_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic                      load,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   output logic [6:0]                seg,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_tick,
   output logic                      pending
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [DIV_W-1:0]          r_div_cnt;
   logic [IDX_W-1:0]          r_idx;
   logic [4*NUM_DIGITS-1:0]   r_disp;
   logic [4*NUM_DIGITS-1:0]   r_pend;
   logic                      r_pending;
   logic [6:0]                r_seg;
   logic [NUM_DIGITS-1:0]     r_an;
   logic                      r_frame_tick;

   logic                      w_term;
   logic                      w_wrap;
   logic [NUM_DIGITS-1:0]     w_show;
   logic [3:0]                w_nibble;
   logic                      w_lit;
   logic [6:0]                w_seg_next;
   logic [NUM_DIGITS-1:0]     w_an_next;

   // Standard active-low hex glyph table
   function automatic logic [6:0] f_decode(input logic [3:0] i_nib);
      logic [6:0] v_seg;
      case (i_nib)
         4'h0:    v_seg = 7'h40;
         4'h1:    v_seg = 7'h79;
         4'h2:    v_seg = 7'h24;
         4'h3:    v_seg = 7'h30;
         4'h4:    v_seg = 7'h19;
         4'h5:    v_seg = 7'h12;
         4'h6:    v_seg = 7'h02;
         4'h7:    v_seg = 7'h78;
         4'h8:    v_seg = 7'h00;
         4'h9:    v_seg = 7'h10;
         4'hA:    v_seg = 7'h08;
         4'hB:    v_seg = 7'h03;
         4'hC:    v_seg = 7'h46;
         4'hD:    v_seg = 7'h21;
         4'hE:    v_seg = 7'h06;
         default: v_seg = 7'h0E;
      endcase
      return v_seg;
   endfunction

   assign w_term = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
   assign w_wrap = w_term && (r_idx == IDX_W'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] w_lz_blank;

   // Walk from the most significant digit down; a digit is a leading zero while
   // every nibble at and above it is zero. Digit 0 always stays visible.
   always_comb begin
      logic v_run;
      w_lz_blank = '0;
      v_run      = 1'b1;
      for (int unsigned j = NUM_DIGITS; j > 1; j--) begin
         v_run             = v_run && (r_disp[4*(j-1) +: 4] == 4'h0);
         w_lz_blank[j-1]   = v_run;
      end
   end

   assign w_show = digit_en & ~w_lz_blank;
`else
   assign w_show = digit_en;
`endif

   // Select the nibble and enable for the digit currently being scanned
   always_comb begin
      w_nibble   = '0;
      w_lit      = 1'b0;
      w_an_next  = '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nibble = r_disp[4*i +: 4];
            w_lit    = w_show[i];
            if (w_show[i]) begin
               w_an_next[i] = 1'b0;
            end
         end
      end
      w_seg_next = w_lit ? f_decode(w_nibble) : 7'h7F;
   end

   // Refresh divider and scan index
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt <= '0;
         r_idx     <= '0;
      end else begin
         if (w_term) begin
            r_div_cnt <= '0;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end
         if (w_wrap) begin
            r_idx <= '0;
         end else if (w_term) begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   // Double-buffered value: load goes to the pending buffer, promoted on wrap.
   // A load coinciding with wrap bypasses the buffer straight into the display.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_disp    <= '0;
         r_pend    <= '0;
         r_pending <= 1'b0;
      end else begin
         if (load) begin
            r_pend <= value;
         end
         if (w_wrap) begin
            if (load) begin
               r_disp <= value;
            end else if (r_pending) begin
               r_disp <= r_pend;
            end
            r_pending <= 1'b0;
         end else if (load) begin
            r_pending <= 1'b1;
         end
      end
   end

   // Registered pin drivers; seg and an update together to avoid ghosting
   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg        <= 7'h7F;
         r_an         <= '1;
         r_frame_tick <= 1'b0;
      end else begin
         r_seg        <= w_seg_next;
         r_an         <= w_an_next;
         r_frame_tick <= w_wrap;
      end
   end

   assign seg        = r_seg;
   assign an         = r_an;
   assign frame_tick = r_frame_tick;
   assign pending    = r_pending;

endmodule
